// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b, CHUNK bits per cycle with a rippled borrow; result valid NCHUNK cycles after accept.
// One operation in flight; in_ready is low from accept until the result is drained, and the result is held while out_ready is low.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] K_LAST = IDXW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if ((CHUNK == 0) ? 1'b1 : ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $fatal(1, "serial_subtractor: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [IDXW-1:0]  k_q, k_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic [BW-1:0]    base;
  logic [CHUNK:0]   sub;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    k_d      = k_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    base = BW'(32'(k_q) * 32'(CHUNK));
    // MSB of the (CHUNK+1)-bit difference is the chunk borrow-out
    sub  = {1'b0, a_q[base +: CHUNK]} - {1'b0, b_q[base +: CHUNK]} - {{CHUNK{1'b0}}, brw_q};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          k_d     = '0;
          brw_d   = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        diff_d[base +: CHUNK] = sub[CHUNK-1:0];
        brw_d = sub[CHUNK];
        k_d   = k_q + IDXW'(1);
        if (k_q == K_LAST) begin
          k_d      = '0;
          borrow_d = sub[CHUNK];
          ovf_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      k_q      <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      k_q      <= k_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor in 16/4 and 8/8 configurations with a result scoreboard.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        tb_in_valid, tb_out_ready;
  logic [15:0] tb_a, tb_b;

  logic        iv16, or16, in_ready16, out_valid16, borrow16, ovf16;
  logic [15:0] diff16;
  logic        iv8, or8, in_ready8, out_valid8, borrow8, ovf8;
  logic [7:0]  diff8;

  assign iv16 = tb_in_valid  && !sel;
  assign or16 = tb_out_ready && !sel;
  assign iv8  = tb_in_valid  && sel;
  assign or8  = tb_out_ready && sel;

  serial_subtractor #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(in_ready16),
    .a(tb_a), .b(tb_b), .out_valid(out_valid16), .out_ready(or16),
    .diff(diff16), .borrow(borrow16), .ovf(ovf16));

  serial_subtractor #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(in_ready8),
    .a(tb_a[7:0]), .b(tb_b[7:0]), .out_valid(out_valid8), .out_ready(or8),
    .diff(diff8), .borrow(borrow8), .ovf(ovf8));

  logic        cur_in_ready, cur_out_valid, cur_borrow, cur_ovf;
  logic [15:0] cur_diff;
  assign cur_in_ready  = sel ? in_ready8  : in_ready16;
  assign cur_out_valid = sel ? out_valid8 : out_valid16;
  assign cur_borrow    = sel ? borrow8    : borrow16;
  assign cur_ovf       = sel ? ovf8       : ovf16;
  assign cur_diff      = sel ? {8'h00, diff8} : diff16;

  typedef struct packed {
    logic [15:0] d;
    logic        br;
    logic        ov;
  } res_t;

  res_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int accepts = 0;
  int exp_accepts = 0;

  always @(posedge clk)
    if (rst_n && ((iv16 && in_ready16) || (iv8 && in_ready8))) accepts++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic narrow);
    res_t r;
    logic [15:0] d16;
    logic [7:0]  d8;
    if (!narrow) begin
      d16  = x - y;
      r.d  = d16;
      r.br = (x < y);
      r.ov = (x[15] ^ y[15]) & (d16[15] ^ x[15]);
    end else begin
      d8   = x[7:0] - y[7:0];
      r.d  = {8'h00, d8};
      r.br = (x[7:0] < y[7:0]);
      r.ov = (x[7] ^ y[7]) & (d8[7] ^ x[7]);
    end
    return r;
  endfunction

  task automatic run_op(input logic [15:0] a_v, input logic [15:0] b_v, input bit churn, input int bp);
    int   n;
    int   lat;
    int   waited;
    res_t e;
    res_t snap;
    n = sel ? 1 : 4;
    waited = 0;
    while (!cur_in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("in_ready_idle", 32'(cur_in_ready), 32'd1);
    if (sel) begin
      a_v = {8'h00, a_v[7:0]};
      b_v = {8'h00, b_v[7:0]};
    end
    sb.push_back(model(a_v, b_v, sel));
    exp_accepts++;
    tb_a = a_v;
    tb_b = b_v;
    tb_in_valid = 1'b1;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    lat = 0;
    while (!cur_out_valid && lat < 40) begin
      if (churn) begin
        tb_in_valid = 1'($urandom_range(0, 1));
        tb_a = 16'($urandom);
        tb_b = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(n));
    snap = '{d: cur_diff, br: cur_borrow, ov: cur_ovf};
    for (int i = 0; i < bp; i++) begin
      if (churn) begin
        tb_in_valid = 1'($urandom_range(0, 1));
        tb_a = 16'($urandom);
        tb_b = 16'($urandom);
      end
      @(posedge clk); #1;
      chk("bp_hold_result", 32'({cur_diff, cur_borrow, cur_ovf}), 32'({snap.d, snap.br, snap.ov}));
      chk("bp_flags", 32'({cur_out_valid, cur_in_ready}), 32'b10);
    end
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("diff", 32'(cur_diff), 32'(e.d));
      chk("borrow", 32'(cur_borrow), 32'(e.br));
      chk("ovf", 32'(cur_ovf), 32'(e.ov));
    end
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b1;
    @(posedge clk); #1;
    tb_out_ready = 1'b0;
    chk("drain_out_valid", 32'(cur_out_valid), 32'd0);
    chk("drain_in_ready", 32'(cur_in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    sel = 1'b0;
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b0;
    tb_a = '0;
    tb_b = '0;
    #2;
    chk("reset16", 32'({in_ready16, out_valid16, diff16, borrow16, ovf16}), 32'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0}));
    chk("reset8", 32'({in_ready8, out_valid8, diff8, borrow8, ovf8}), 32'({1'b1, 1'b0, 8'h0, 1'b0, 1'b0}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd1000, 16'd2000, 1'b0, 0);
    run_op(16'd2000, 16'd1000, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 5);
    run_op(16'hABCD, 16'h1357, 1'b1, 3);
    run_op(16'h0F0F, 16'hF0F0, 1'b1, 2);

    // abort an operation in its second CALC cycle
    tb_a = 16'h1234;
    tb_b = 16'h0042;
    tb_in_valid = 1'b1;
    exp_accepts++;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midcalc_reset", 32'({in_ready16, out_valid16, diff16, borrow16, ovf16}), 32'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0}));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_spurious_valid", 32'(out_valid16), 32'd0);
    end
    run_op(16'd5, 16'd5, 1'b0, 0);

    for (int i = 0; i < 1000; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

    sel = 1'b1;
    run_op(16'd10, 16'd20, 1'b0, 0);
    run_op(16'h007F, 16'h00FF, 1'b0, 0);
    run_op(16'h0080, 16'h0001, 1'b0, 2);
    for (int i = 0; i < 1000; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

    chk("accept_count", 32'(accepts), 32'(exp_accepts));
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parameterized multi-cycle subtractor; companion to the team's combinational parameterized adder.
- Computes diff = a - b over WIDTH bits, CHUNK bits per clock, with a rippled borrow register.
- Valid/ready handshakes on input and output, so it drops into streaming datapaths where area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits subtracted per CALC cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of CALC cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend, unsigned or two's-complement
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b mod 2^WIDTH
- borrow  output  1  1 when a < b unsigned
- ovf  output  1  signed overflow: sign(a) != sign(b) and sign(diff) != sign(a)

Behaviour:
- Reset (rst_n low, async): state=IDLE; in_ready=1, out_valid=0, diff=0, borrow=0, ovf=0; chunk index=0; internal borrow=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge t: capture a and b into registers, clear chunk index and borrow, go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge computes {bo, d} = A[k*CHUNK +: CHUNK] - B[k*CHUNK +: CHUNK] - borrow_reg, where bo is the chunk borrow-out.
  - Writes d into diff[k*CHUNK +: CHUNK], sets borrow_reg=bo, increments k.
  - At the edge processing k=NCHUNK-1: go to DONE, set out_valid=1, borrow=final bo, ovf computed from captured sign bits and final diff MSB.
- Latency: out_valid rises at edge t+NCHUNK. NCHUNK=1 gives one cycle of latency.
- DONE:
  - out_valid=1; diff, borrow and ovf held stable while out_ready=0 (no change under backpressure).
  - On out_valid&&out_ready: out_valid=0, go to IDLE, in_ready=1 next cycle.
  - in_ready stays 0 throughout DONE; there is no overlap of input and output handshakes.
- Throughput: one operation per NCHUNK+2 cycles at best (accept, NCHUNK CALC, drain).
- in_valid is ignored outside IDLE. Changes on a/b after the capture edge must not affect the result.
- diff is registered: outside DONE it shows the last result or partial results and is meaningful only with out_valid.
- Wrap-around: results are mod 2^WIDTH; borrow and ovf are independent flags, both may be set (e.g. 0x7FFF-0xFFFF: borrow=1, ovf=1).
- Reset asserted mid-CALC or in DONE aborts the operation immediately and returns to IDLE reset values; no spurious out_valid after release.
- Elaboration must fail (assertion) if WIDTH % CHUNK != 0 or CHUNK == 0.

Test Plan:
- WIDTH=16, CHUNK=4: a=1000, b=2000 accepted at edge t -> out_valid at edge t+4; diff=16'hFC18, borrow=1, ovf=0.
- a=2000, b=1000 -> diff=1000, borrow=0, ovf=0. Then a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> diff/borrow/ovf stable and in_ready=0 throughout; out_ready=1 -> out_valid falls next edge, in_ready=1.
- Input churn: toggle in_valid and randomize a/b during CALC and DONE -> no extra accepts, result matches the captured operands.
- Reset: drop rst_n at the 2nd CALC cycle -> outputs immediately at reset values; after release, a=5, b=5 gives diff=0, borrow=0, ovf=0 at t+4.
- WIDTH=8, CHUNK=8: a=10, b=20 -> out_valid at t+1, diff=8'hF6, borrow=1; random 1000-vector sweep vs. the a-b golden model in both configurations.
